// File: rtl/mem_ctrl.sv
// Load/store request controller in front of a 256x8 byte-array memory with a 16-bit big-endian word port.
// It sequences registered read/write strobes, handles byte loads/stores (RMW) and rejects misaligned word accesses.
module mem_ctrl #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic          req_byte,
   input  logic          req_sext,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          resp_valid,
   output logic [DW-1:0] resp_rdata,
   output logic          resp_err,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_read,
   output logic          mem_write,
   input  logic [DW-1:0] mem_rdata
);

   // Handshake: a request transfers on the rising edge where req_valid && req_ready;
   // req_ready is high only in IDLE, and resp_valid is a single-cycle pulse that is never back-pressured.

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_WRITE   = 3'd3,
      ST_RESP    = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          we_q, we_d;
   logic          byte_q, byte_d;
   logic          sext_q, sext_d;
   logic          lane_q, lane_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          err_q, err_d;

   logic          accept;
   logic          misaligned;
   logic          word_store_q;
   logic [7:0]    lane_byte;
   logic [DW-1:0] load_value;
   logic [DW-1:0] merged_word;

   assign accept       = (state_q == ST_IDLE) && req_valid;
   assign misaligned   = !req_byte && req_addr[0];
   assign word_store_q = we_q && !byte_q;

   // Big-endian: lane 0 (even byte address) lives in the high half of the word.
   assign lane_byte   = lane_q ? mem_rdata[7:0] : mem_rdata[DW-1:8];
   assign merged_word = lane_q ? {mem_rdata[DW-1:8], wdata_q[7:0]}
                               : {wdata_q[7:0], mem_rdata[7:0]};

   always_comb begin
      load_value = mem_rdata;
      if (byte_q) begin
         if (sext_q) load_value = {{(DW-8){lane_byte[7]}}, lane_byte};
         else        load_value = {{(DW-8){1'b0}}, lane_byte};
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         byte_q  <= 1'b0;
         sext_q  <= 1'b0;
         lane_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         byte_q  <= byte_d;
         sext_q  <= sext_d;
         lane_q  <= lane_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = misaligned ? ST_RESP : ST_ISSUE;
         end
         ST_ISSUE:   state_d = word_store_q ? ST_RESP : ST_CAPTURE;
         ST_CAPTURE: state_d = we_q ? ST_WRITE : ST_RESP;
         ST_WRITE:   state_d = ST_RESP;
         ST_RESP:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Request latch and response data; resp_rdata/resp_err change only on entry to RESP.
   always_comb begin
      we_d    = we_q;
      byte_d  = byte_q;
      sext_d  = sext_q;
      lane_d  = lane_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               we_d    = req_we;
               byte_d  = req_byte;
               sext_d  = req_sext;
               lane_d  = req_addr[0];
               addr_d  = req_byte ? {req_addr[AW-1:1], 1'b0} : req_addr;
               wdata_d = req_wdata;
               if (misaligned) begin
                  rdata_d = '0;
                  err_d   = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            if (word_store_q) begin
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         ST_CAPTURE: begin
            if (we_q) begin
               wdata_d = merged_word;
            end else begin
               rdata_d = load_value;
               err_d   = 1'b0;
            end
         end
         ST_WRITE: begin
            rdata_d = '0;
            err_d   = 1'b0;
         end
         default: ;
      endcase
   end

   // Outputs decode registered state only; nothing from req_* reaches the memory port.
   always_comb begin
      req_ready  = (state_q == ST_IDLE);
      resp_valid = (state_q == ST_RESP);
      mem_read   = (state_q == ST_ISSUE) && !word_store_q;
      mem_write  = ((state_q == ST_ISSUE) && word_store_q) || (state_q == ST_WRITE);
      mem_addr   = addr_q;
      mem_wdata  = wdata_q;
      resp_rdata = rdata_q;
      resp_err   = err_q;
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural 256x8 big-endian memory behind it.
// Each request is traced cycle by cycle after acceptance and compared against hand-derived timing and data.
module tb_mem_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_byte;
  logic        req_sext;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_rdata;

  logic [7:0]  mem [256];

  int checks;
  int failures;

  int rd_cnt, wr_cnt, rd_cyc, wr_cyc, resp_cyc, both_hi;
  int rd_addr, wr_addr, wr_data, rsp_data, rsp_err;

  mem_ctrl #(.AW(8), .DW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_byte   (req_byte),
    .req_sext   (req_sext),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: registered read, synchronous write, high byte at even address
  always @(posedge clk) begin
    if (mem_read) mem_rdata <= {mem[mem_addr], mem[mem_addr | 8'h01]};
    if (mem_write) begin
      mem[mem_addr]         <= mem_wdata[15:8];
      mem[mem_addr | 8'h01] <= mem_wdata[7:0];
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drive one request, then trace up to 8 cycles after the accepting edge
  task automatic run_req(input string tag, input logic we, input logic byt, input logic sext,
                         input logic [7:0] addr, input logic [15:0] wdata);
    @(negedge clk);
    req_we    = we;
    req_byte  = byt;
    req_sext  = sext;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    check({tag, "_ready_in"}, int'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    rd_cnt = 0; wr_cnt = 0; rd_cyc = 0; wr_cyc = 0; resp_cyc = 0; both_hi = 0;
    rd_addr = -1; wr_addr = -1; wr_data = -1; rsp_data = -1; rsp_err = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_read && mem_write) both_hi++;
      if (mem_read) begin
        rd_cnt++; rd_cyc = k; rd_addr = int'(mem_addr);
      end
      if (mem_write) begin
        wr_cnt++; wr_cyc = k; wr_addr = int'(mem_addr); wr_data = int'(mem_wdata);
      end
      if (resp_valid) begin
        resp_cyc = k; rsp_data = int'(resp_rdata); rsp_err = int'(resp_err);
        break;
      end
    end
    @(negedge clk);
    check({tag, "_ready_after"}, int'(req_ready), 1);
    check({tag, "_resp_one_pulse"}, int'(resp_valid), 0);
    check({tag, "_rd_wr_overlap"}, both_hi, 0);
  endtask

  task automatic do_load(input string tag, input logic byt, input logic sext,
                         input logic [7:0] addr, input int exp_addr, input int exp_data);
    run_req(tag, 1'b0, byt, sext, addr, 16'h0000);
    check({tag, "_rd_cnt"}, rd_cnt, 1);
    check({tag, "_rd_cyc"}, rd_cyc, 1);
    check({tag, "_rd_addr"}, rd_addr, exp_addr);
    check({tag, "_wr_cnt"}, wr_cnt, 0);
    check({tag, "_resp_cyc"}, resp_cyc, 3);
    check({tag, "_rdata"}, rsp_data, exp_data);
    check({tag, "_err"}, rsp_err, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h04] = 8'h12; mem[8'h05] = 8'h34;
    mem[8'h06] = 8'hDE; mem[8'h07] = 8'hAD;
    mem_rdata = 16'h0000;
    req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_sext = 1'b0;
    req_addr = 8'h00; req_wdata = 16'h0000;
    reset = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", int'(req_ready), 1);
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_resp_err", int'(resp_err), 0);
    check("rst_resp_rdata", int'(resp_rdata), 0);
    check("rst_mem_read", int'(mem_read), 0);
    check("rst_mem_write", int'(mem_write), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_wdata", int'(mem_wdata), 0);
    reset = 1'b1;

    do_load("wload04", 1'b0, 1'b0, 8'h04, 'h04, 'h1234);
    do_load("bload07s", 1'b1, 1'b1, 8'h07, 'h06, 'hFFAD);
    do_load("bload07z", 1'b1, 1'b0, 8'h07, 'h06, 'h00AD);
    do_load("bload06z", 1'b1, 1'b0, 8'h06, 'h06, 'h00DE);
    do_load("bload06s", 1'b1, 1'b1, 8'h06, 'h06, 'hFFDE);

    // byte store to odd lane; upper wdata byte must not leak into memory
    run_req("bstore05", 1'b1, 1'b1, 1'b0, 8'h05, 16'h775A);
    check("bstore05_rd_cyc", rd_cyc, 1);
    check("bstore05_rd_addr", rd_addr, 'h04);
    check("bstore05_wr_cnt", wr_cnt, 1);
    check("bstore05_wr_cyc", wr_cyc, 3);
    check("bstore05_wr_addr", wr_addr, 'h04);
    check("bstore05_wr_data", wr_data, 'h125A);
    check("bstore05_resp_cyc", resp_cyc, 4);
    check("bstore05_rdata", rsp_data, 0);
    check("bstore05_err", rsp_err, 0);
    do_load("wload04_after", 1'b0, 1'b0, 8'h04, 'h04, 'h125A);

    run_req("wstore08", 1'b1, 1'b0, 1'b0, 8'h08, 16'hBEEF);
    check("wstore08_rd_cnt", rd_cnt, 0);
    check("wstore08_wr_cnt", wr_cnt, 1);
    check("wstore08_wr_cyc", wr_cyc, 1);
    check("wstore08_wr_addr", wr_addr, 'h08);
    check("wstore08_wr_data", wr_data, 'hBEEF);
    check("wstore08_resp_cyc", resp_cyc, 2);
    check("wstore08_rdata", rsp_data, 0);
    do_load("wload08", 1'b0, 1'b0, 8'h08, 'h08, 'hBEEF);

    run_req("wload03", 1'b0, 1'b0, 1'b0, 8'h03, 16'h0000);
    check("wload03_resp_cyc", resp_cyc, 1);
    check("wload03_err", rsp_err, 1);
    check("wload03_rdata", rsp_data, 0);
    check("wload03_rd_cnt", rd_cnt, 0);
    check("wload03_wr_cnt", wr_cnt, 0);
    check("wload03_err_held", int'(resp_err), 1);

    run_req("wstore09", 1'b1, 1'b0, 1'b0, 8'h09, 16'hCAFE);
    check("wstore09_resp_cyc", resp_cyc, 1);
    check("wstore09_err", rsp_err, 1);
    check("wstore09_wr_cnt", wr_cnt, 0);

    // top-of-memory byte store uses word 0xFE
    run_req("bstoreFF", 1'b1, 1'b1, 1'b0, 8'hFF, 16'h0011);
    check("bstoreFF_rd_addr", rd_addr, 'hFE);
    check("bstoreFF_wr_addr", wr_addr, 'hFE);
    check("bstoreFF_wr_data", wr_data, 'h0011);
    check("bstoreFF_resp_cyc", resp_cyc, 4);
    do_load("bloadFE", 1'b1, 1'b0, 8'hFE, 'hFE, 'h0000);
    do_load("wloadFE", 1'b0, 1'b0, 8'hFE, 'hFE, 'h0011);

    // reset during CAPTURE of a byte store to word 0x04 (holds 0x125A)
    @(negedge clk);
    req_we = 1'b1; req_byte = 1'b1; req_sext = 1'b0;
    req_addr = 8'h04; req_wdata = 16'h0099; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstmid_issue_read", int'(mem_read), 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstmid_read_drop", int'(mem_read), 0);
    check("rstmid_write_drop", int'(mem_write), 0);
    check("rstmid_ready", int'(req_ready), 1);
    rd_cnt = 0; wr_cnt = 0; resp_cyc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) reset = 1'b1;
      if (mem_read) rd_cnt++;
      if (mem_write) wr_cnt++;
      if (resp_valid) resp_cyc++;
    end
    check("rstmid_no_write", wr_cnt, 0);
    check("rstmid_no_read", rd_cnt, 0);
    check("rstmid_no_resp", resp_cyc, 0);
    check("rstmid_ready_after", int'(req_ready), 1);
    do_load("rstmid_word", 1'b0, 1'b0, 8'h04, 'h04, 'h125A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Load/store request controller sitting directly upstream of the 256x8 byte-array data memory (16-bit big-endian word port, registered read, synchronous write).
- Accepts one request at a time from the datapath over a valid/ready handshake and sequences the memory's read and write strobes.
- Returns read data through a one-cycle response pulse.
- Adds byte loads (zero- or sign-extended), byte stores via read-modify-write, and alignment checking for word accesses.

Parameters:
- AW, 8, address width; must match the memory address port.
- DW, 16, data width; fixed at 2 bytes, big-endian (high byte at even address).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_byte  input  1  1 = byte access, 0 = word access
- req_sext  input  1  byte load: 1 = sign-extend, 0 = zero-extend; ignored otherwise
- req_addr  input  AW  byte address
- req_wdata  input  DW  store data; a byte store uses [7:0]
- resp_valid  output  1  one-cycle response pulse; the consumer always accepts
- resp_rdata  output  DW  load result; 0 for stores and errors
- resp_err  output  1  qualifies resp_valid: word access to an odd address
- mem_addr  output  AW  to memory addr_in
- mem_wdata  output  DW  to memory data_in
- mem_read  output  1  to memory MemRead
- mem_write  output  1  to memory MemWrite
- mem_rdata  input  DW  from memory data_out; valid the cycle after mem_read is sampled

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - resp_valid, resp_err, mem_read and mem_write are 0.
  - resp_rdata, mem_addr and mem_wdata are 0.
  - req_ready is 1.
  - Any in-flight request is dropped: no response, no further memory strobes.
- Accept: on the edge where req_valid && req_ready, latch we, byte, sext, addr and wdata.
  - Word address = addr with bit 0 cleared for byte accesses; addr unchanged for word accesses.
- States: IDLE, ISSUE, CAPTURE, WRITE, RESP.
- mem_read, mem_write, mem_addr and mem_wdata are driven from registers only. There is no combinational path from req_* to the memory.
- Transitions, for accept at edge n (cycle n+1 is the first cycle after that edge):
  - Word load: ISSUE(n+1, mem_read=1) -> CAPTURE(n+2, sample mem_rdata) -> RESP(n+3); resp_rdata = mem_rdata.
  - Byte load: same timing as a word load.
    - Lane = addr[0]: 0 selects [15:8], 1 selects [7:0].
    - The selected byte is extended to 16 bits per sext.
  - Word store: ISSUE(n+1, mem_write=1, mem_wdata=wdata) -> RESP(n+2).
  - Byte store (read-modify-write):
    - ISSUE(n+1, mem_read=1) -> CAPTURE(n+2, merge) -> WRITE(n+3, mem_write=1) -> RESP(n+4).
    - Merge: the lane byte is replaced by wdata[7:0]; the other byte keeps the old value from mem_rdata.
  - Misaligned word access (byte=0, addr[0]=1): RESP(n+1) with resp_err=1 and resp_rdata=0. No memory strobe is issued.
- RESP lasts one cycle: resp_valid=1, then the state returns to IDLE. req_ready is next high in cycle n+LAT+1.
- mem_read and mem_write are never high in the same cycle. Each strobe is exactly one cycle wide.
- mem_addr holds the word address from ISSUE through WRITE.
- resp_rdata and resp_err hold their values until the next RESP. Only resp_valid pulses.
- Address 0xFE/0xFF byte accesses use word 0xFE. There is no wrap to 0x00.
- req_valid asserted outside IDLE is ignored and not latched. The requester must hold its request until it sees req_ready.

Test Plan:
- Memory model preloaded with 0x1234 at 0x04; word load at 0x04 -> mem_read pulses in cycle n+1; resp_valid in n+3 with rdata=0x1234, err=0.
- Memory model preloaded with 0xDEAD at 0x06; byte load at 0x07 with sext=1 -> rdata=0xFFAD; same with sext=0 -> 0x00AD; byte load at 0x06 with sext=0 -> 0x00DE.
- Byte store 0x5A to 0x05 (word 0x1234) -> read at 0x04, then write 0x125A in cycle n+3; resp in n+4; a following word load at 0x04 returns 0x125A.
- Word store 0xBEEF to 0x08 -> single mem_write in n+1 with mem_wdata=0xBEEF; resp in n+2; word load at 0x08 returns 0xBEEF.
- Word load at 0x03 -> resp_valid in n+1 with err=1, rdata=0; mem_read and mem_write stay 0.
- Reset asserted during CAPTURE of a byte store -> strobes drop at once; no WRITE or RESP; req_ready=1 after release; memory word is unchanged.
